// File: rtl/score_bcd_converter_pkg.sv
// score_bcd_pkg: shared types and constants for the score binary-to-BCD converter.
//   state_e    - converter FSM states
//   BCD_MAX    - largest displayable score; anything above saturates
//   BCD_NINE   - digit value shown on saturation
//   BCD_ADJ_TH - double-dabble threshold (nibble >= 5 gets +3)
//   blank_mask - leading-zero mask for a 4-digit BCD word (bit 0 never blank)
package score_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned BCD_MAX    = 9999;
    localparam logic [3:0]  BCD_NINE   = 4'd9;
    localparam logic [3:0]  BCD_ADJ_TH = 4'd5;

    // Blanking chains from the top digit down; an interior zero stays lit.
    function automatic logic [3:0] blank_mask(input logic [15:0] d);
        logic [3:0] m;
        m    = '0;
        m[3] = (d[15:12] == 4'd0);
        m[2] = m[3] & (d[11:8] == 4'd0);
        m[1] = m[2] & (d[7:4] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/score_bcd_converter_if.sv
// score_bcd_converter_if: bundle between the score source / display side and
// the converter.
//   score          - binary score (quasi-static, from a divided-clock domain)
//   digit0..digit3 - BCD digits, digit0 = ones
//   blank          - leading-zero mask, bit i = digit i blank
//   ovf            - last converted score exceeded 9999
//   valid          - at least one conversion completed since reset
//   busy           - conversion in progress
//   done           - one-cycle pulse when digits update
// modport master: score source / display consumer; modport slave: converter.
interface score_bcd_converter_if #(
    parameter int SCORE_W = 16
);
    import score_bcd_pkg::*;

    logic [SCORE_W-1:0] score;
    logic [3:0]         digit0;
    logic [3:0]         digit1;
    logic [3:0]         digit2;
    logic [3:0]         digit3;
    logic [3:0]         blank;
    logic               ovf;
    logic               valid;
    logic               busy;
    logic               done;

    modport master (
        output score,
        input  digit0, digit1, digit2, digit3, blank, ovf, valid, busy, done
    );

    modport slave (
        input  score,
        output digit0, digit1, digit2, digit3, blank, ovf, valid, busy, done
    );

endinterface

// File: rtl/score_bcd_converter_bcd_digit_adj.sv
// bcd_digit_adj: combinational double-dabble nibble adjust.
//   din_i  - BCD nibble before the shift
//   dout_o - din_i + 3 when din_i >= 5, else din_i
module bcd_digit_adj
    import score_bcd_pkg::*;
(
    input  logic [3:0] din_i,
    output logic [3:0] dout_o
);

    always_comb begin
        dout_o = din_i;
        if (din_i >= BCD_ADJ_TH) begin
            dout_o = din_i + 4'd3;
        end
    end

endmodule

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: sequential binary-to-BCD converter for the score display.
// Samples the score every clock, converts it with one shift-and-add-3 step per
// cycle once it has changed and held for two samples, and presents registered
// digits, a leading-zero mask and a saturation flag (scores > 9999 show 9999).
//   ClkPort - system clock
//   Reset_n - asynchronous active-low reset
//   bus     - slave side of score_bcd_converter_if (score in, digits/status out)
module score_bcd_converter
    import score_bcd_pkg::*;
#(
    parameter int SCORE_W = 16,
    parameter int DIGITS  = 4
) (
    input  logic ClkPort,
    input  logic Reset_n,
    score_bcd_converter_if.slave bus
);

    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] last_q, last_d;
    logic               first_q, first_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic [3:0]         blank_q, blank_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din_i  (bcd_q[4*g +: 4]),
            .dout_o (bcd_adj[4*g +: 4])
        );
    end

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            score_q  <= '0;
            last_q   <= '0;
            first_q  <= 1'b1;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            digits_q <= '0;
            blank_q  <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            last_q   <= last_d;
            first_q  <= first_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        score_d  = bus.score;
        last_d   = last_q;
        first_d  = first_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        digits_d = digits_q;
        blank_d  = blank_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Two matching samples filter the divided-clock source; only a
                // genuinely new value (or the first after reset) is converted.
                if ((bus.score == score_q) && ((score_q != last_q) || first_q)) begin
                    last_d  = score_q;
                    first_d = 1'b0;
                    busy_d  = 1'b1;
                    if (32'(score_q) > BCD_MAX) begin
                        sat_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        sat_d   = 1'b0;
                        bin_d   = score_q;
                        bcd_d   = '0;
                        cnt_d   = CNT_W'(SCORE_W);
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // Adjust precedes each shift, so the final result needs no fix-up.
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digits_d = sat_q ? {DIGITS{BCD_NINE}} : bcd_q;
                blank_d  = blank_mask(digits_d);
                ovf_d    = sat_q;
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.digit0 = digits_q[3:0];
    assign bus.digit1 = digits_q[7:4];
    assign bus.digit2 = digits_q[11:8];
    assign bus.digit3 = digits_q[15:12];
    assign bus.blank  = blank_q;
    assign bus.ovf    = ovf_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter: directed, table-driven check of score_bcd_converter.
// Edge numbering: edge 0 is the first rising edge that samples a new score;
// after a reset release, edge 1 is the first rising edge with reset high.
module tb_score_bcd_converter;

    localparam int SCORE_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    score_bcd_converter_if #(.SCORE_W(SCORE_W)) bus ();

    score_bcd_converter #(
        .SCORE_W (SCORE_W),
        .DIGITS  (4)
    ) dut (
        .ClkPort (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [15:0] score;
        logic [15:0] digits;   // {d3,d2,d1,d0}
        logic [3:0]  blank;
        logic        ovf;
        int          lat;      // update edge, counted from edge 0
    } vec_t;

    vec_t vecs[9];
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] digs();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for done, numbering edges from first_k; flags any output movement
    // before the update edge and counts cycles sampled with busy high.
    task automatic wait_update(input int first_k, output int lat, output int busy_cnt,
                               output bit partial);
        logic [15:0] pd;
        logic [3:0]  pb;
        logic        po;
        pd       = digs();
        pb       = bus.blank;
        po       = bus.ovf;
        lat      = -1;
        busy_cnt = 0;
        partial  = 1'b0;
        for (int k = first_k; k <= first_k + 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (digs() !== pd || bus.blank !== pb || bus.ovf !== po) partial = 1'b1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " digits"}, 32'(digs()), 32'h0);
        chk({tag, " blank"},  32'(bus.blank), 32'h0);
        chk({tag, " ovf"},    32'(bus.ovf), 32'h0);
        chk({tag, " valid"},  32'(bus.valid), 32'h0);
        chk({tag, " busy"},   32'(bus.busy), 32'h0);
        chk({tag, " done"},   32'(bus.done), 32'h0);
    endtask

    initial begin
        int lat, bc;
        bit partial, seen;

        vecs[0] = '{16'd1234,  16'h1234, 4'b0000, 1'b0, 18};
        vecs[1] = '{16'd10000, 16'h9999, 4'b0000, 1'b1, 2};
        vecs[2] = '{16'd65535, 16'h9999, 4'b0000, 1'b1, 2};
        vecs[3] = '{16'd7,     16'h0007, 4'b1110, 1'b0, 18};
        vecs[4] = '{16'd9999,  16'h9999, 4'b0000, 1'b0, 18};
        vecs[5] = '{16'd0,     16'h0000, 4'b1110, 1'b0, 18};
        vecs[6] = '{16'd100,   16'h0100, 4'b1000, 1'b0, 18};
        vecs[7] = '{16'd10,    16'h0010, 4'b1100, 1'b0, 18};
        vecs[8] = '{16'd5,     16'h0005, 4'b1110, 1'b0, 18};

        // Reset release with score = 0: capture at edge 1, update at edge 18.
        bus.score = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            if (bus.valid || bus.done || digs() != 16'h0 || bus.blank != 4'h0 || bus.ovf)
                seen = 1'b1;
        end
        chk("rst0 early_change", 32'(seen), 32'h0);
        @(posedge clk);
        #1;
        chk("rst0 done@18", 32'(bus.done), 32'h1);
        chk("rst0 valid", 32'(bus.valid), 32'h1);
        chk("rst0 digits", 32'(digs()), 32'h0);
        chk("rst0 blank", 32'(bus.blank), 32'b1110);

        // Table-driven conversions.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.score = vecs[i].score[SCORE_W-1:0];
            wait_update(0, lat, bc, partial);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d digits", i), 32'(digs()), 32'(vecs[i].digits));
            chk($sformatf("v%0d blank", i), 32'(bus.blank), 32'(vecs[i].blank));
            chk($sformatf("v%0d ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
            chk($sformatf("v%0d valid", i), 32'(bus.valid), 32'h1);
            chk($sformatf("v%0d partial", i), 32'(partial), 32'h0);
            chk($sformatf("v%0d busy_cycles", i), 32'(bc), 32'(vecs[i].lat - 1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done_width", i), 32'(bus.done), 32'h0);
            repeat (2) @(posedge clk);
        end

        // One-cycle glitch 5 -> 6 -> 5: never two equal samples of 6, and 5 == last.
        @(negedge clk);
        bus.score = 16'd6;
        @(negedge clk);
        bus.score = 16'd5;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        chk("glitch activity", 32'(seen), 32'h0);
        chk("glitch digits", 32'(digs()), 32'h0005);

        // 42, then 57 after edge 6 (five cycles after capture at edge 1).
        // 57 is captured at edge 19, right after the update, so it lands at 36.
        @(negedge clk);
        bus.score = 16'd42;
        repeat (7) @(posedge clk);
        @(negedge clk);
        bus.score = 16'd57;
        wait_update(7, lat, bc, partial);
        chk("chg first latency", 32'(lat), 32'd18);
        chk("chg first digits", 32'(digs()), 32'h0042);
        chk("chg first blank", 32'(bus.blank), 32'b1100);
        wait_update(19, lat, bc, partial);
        chk("chg second latency", 32'(lat), 32'd36);
        chk("chg second digits", 32'(digs()), 32'h0057);
        chk("chg second partial", 32'(partial), 32'h0);

        // Reset mid-SHIFT of 321. After release score_q restarts at 0, so edge 1
        // samples 321, edge 2 captures and the update lands at edge 19.
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.score = 16'd321;
        repeat (8) @(posedge clk);
        #2;
        chk("midrst busy_before", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_update(1, lat, bc, partial);
        chk("midrst latency", 32'(lat), 32'd19);
        chk("midrst digits", 32'(digs()), 32'h0321);
        chk("midrst blank", 32'(bus.blank), 32'b1000);
        chk("midrst ovf", 32'(bus.ovf), 32'h0);
        chk("midrst valid", 32'(bus.valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
